neuron_controller: RTL and testbench
====================================

# neuron_controller

Control unit that sequences one neuron evaluation on the MAC datapath. It accepts a start request, then drives the datapath's `init`, `ld_reg` and `inc` strobes through clear, N multiply-accumulate steps and one bias step. It then captures the 21-bit MAC output through a ReLU into a held result register and presents it with a valid/ack handshake. It sits between the layer sequencer and the datapath; the datapath responds, this block initiates.

## Interface
- `N`, default 2: number of input/weight byte pairs per evaluation; must be ≥ 1.
- `ACC_W`, default 21: MAC result width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request one evaluation; sampled only in IDLE.
- `mac_result`  in  ACC_W  datapath accumulator output, two's complement.
- `result_ack`  in  1  consumer has taken `result`.
- `init`  out  1  datapath strobe: clear the accumulator and the input-selection index.
- `ld_reg`  out  1  datapath strobe: load the accumulator.
- `inc`  out  1  datapath strobe: with `ld_reg`, add the current product and advance the index; without `inc`, `ld_reg` adds the bias.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  `result` holds a finished evaluation.
- `result`  out  ACC_W  ReLU of the captured `mac_result`.

## Operation
- States and transitions:
  - IDLE: go to CLR when `start` is high.
  - CLR: assert `init` for 1 cycle; go to ACC with step count 0.
  - ACC: assert `ld_reg` and `inc` each cycle and increment the step count. When the count reaches N-1, go to BIAS.
  - BIAS: assert `ld_reg` with `inc` low for 1 cycle; go to CAP.
  - CAP: register `result` ← (`mac_result[ACC_W-1]` ? 0 : `mac_result`) and set `result_valid`; go to DONE.
  - DONE: hold `result` and `result_valid`. When `result_ack` is high, clear `result_valid` and go to IDLE.
- All strobes are Moore outputs, decoded from registered state only.
- `start` outside IDLE is ignored. It is not queued.
- `result_ack` outside DONE is ignored.
- Step counter width is clog2(N), minimum 1. It does not wrap mid-evaluation.
- ReLU: sign bit set → all zeros. Otherwise the value passes unchanged. No saturation.

## Timing
- Reset values: state IDLE, `init`/`ld_reg`/`inc`/`busy`/`result_valid` = 0, `result` = 0, step count = 0.
- `start` high at edge k:
  - `init` is high in cycle k+1.
  - ACC occupies cycles k+2 … k+N+1.
  - BIAS is at k+N+2.
  - CAP samples `mac_result` at k+N+3.
  - `result_valid` rises at k+N+4.
  - Latency from `start` to `result_valid` is N+4 cycles.
- `result_ack` seen in DONE at edge m: `result_valid` is 0 and state is IDLE from m+1. A `start` at m+1 begins a new evaluation, so back-to-back throughput is N+5 cycles.
- `start` and `result_ack` high together in DONE: ack is taken, start is dropped.
- `rst` mid-evaluation: all outputs return to reset values immediately. The datapath is left as-is and is cleared by the next CLR.
- `result` changes only in CAP and on reset.

## Structure
- Shared package `neuron_pkg`:
  - state enum {IDLE, CLR, ACC, BIAS, CAP, DONE}
  - constant `ACC_W` = 21
  - `relu` function on ACC_W bits
- One sub-module, `neuron_step_counter`:
  - parameterised by N.
  - inputs: clear, enable.
  - outputs: count, `last` (count == N-1).
  - async reset.

## Test plan
- N=2, reset then `start` pulse at cycle 0 with `mac_result` = 21'd300 → `init` at 1, `ld_reg`&`inc` at 2–3, `ld_reg`-only at 4, `result_valid`=1 with `result`=300 at 6; held until ack.
- `mac_result` = 21'h1FFFF6 (−10) during CAP → `result` = 0, `result_valid` = 1.
- `start` held high continuously with `result_ack` low → exactly one evaluation; `busy` stays high in DONE; no second CLR until ack.
- `rst` asserted during ACC step 1 (N=4) → strobes drop immediately, `busy`=0, `result`=0; subsequent `start` gives a full CLR + 4 ACC + BIAS sequence.
- `result_ack` and `start` together in DONE → IDLE next cycle, `init` not asserted; `start` the following cycle → `init` one cycle later.
- N=1 → ACC lasts exactly 1 cycle; `result_valid` 5 cycles after `start`.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron evaluation controller.
package neuron_pkg;

  localparam int ACC_W = 21;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACC,
    BIAS,
    CAP,
    DONE
  } state_t;

  // Rectified linear unit on a two's-complement accumulator value.
  function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v);
    return v[ACC_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/neuron_step_counter.sv
// Counts multiply-accumulate steps; saturates at N-1 so it never wraps mid-evaluation.
module neuron_step_counter
  import neuron_pkg::*;
#(
  parameter  int N  = 2,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count = count_q;
  assign last  = (count_q == CW'(N - 1));

  // Next count: clear wins, otherwise advance until the final step is reached.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !last) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/neuron_controller.sv
// Sequences one neuron evaluation: clear, N MAC steps, bias, ReLU capture, valid/ack.
module neuron_controller #(
  parameter int N     = 2,
  parameter int ACC_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] mac_result,
  input  logic             result_ack,
  output logic             init,
  output logic             ld_reg,
  output logic             inc,
  output logic             busy,
  output logic             result_valid,
  output logic [ACC_W-1:0] result
);
  import neuron_pkg::*;

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [ACC_W-1:0] result_q;
  logic [ACC_W-1:0] result_d;
  logic [ACC_W-1:0] relu_val;
  logic [CW-1:0]    step_cnt;
  logic             step_last;

  neuron_step_counter #(.N(N)) u_step_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == CLR),
    .enable (state_q == ACC),
    .count  (step_cnt),
    .last   (step_last)
  );

  // Shared ReLU helper is fixed-width; other widths use an equivalent local form.
  if (ACC_W == neuron_pkg::ACC_W) begin : g_relu_pkg
    assign relu_val = relu(mac_result);
  end else begin : g_relu_local
    assign relu_val = mac_result[ACC_W-1] ? '0 : mac_result;
  end

  // Moore strobes decoded from the registered state.
  assign init         = (state_q == CLR);
  assign ld_reg       = (state_q == ACC) || (state_q == BIAS);
  assign inc          = (state_q == ACC);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

  // Next-state and result-capture logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLR;
      CLR:     state_d = ACC;
      ACC:     if (step_last) state_d = BIAS;
      BIAS:    state_d = CAP;
      CAP: begin
        result_d = relu_val;
        state_d  = DONE;
      end
      DONE:    if (result_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and held-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  // The step count never runs past the final MAC step.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACC) begin
      assert (step_cnt <= CW'(N - 1));
    end
  end

endmodule

// File: tb/tb_neuron_controller.sv
// Randomized scoreboard bench for neuron_controller at N = 2, 4 and 1.
module tb_neuron_controller;

  localparam int W   = 21;
  localparam int NUM = 3;
  localparam int NS [NUM] = '{2, 4, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [N=%0d] actual=%0h expected=%0h", name, NS[inst], act, exp);
    end
  endtask

  for (genvar g = 0; g < NUM; g++) begin : g_inst
    localparam int N = NS[g];

    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         ack   = 1'b0;
    logic [W-1:0] mac   = '0;
    logic [W-1:0] result;
    logic         init, ld_reg, inc, busy, result_valid;

    neuron_controller #(.N(N), .ACC_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mac_result   (mac),
      .result_ack   (ack),
      .init         (init),
      .ld_reg       (ld_reg),
      .inc          (inc),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result)
    );

    // Reference: t is the cycle position within an evaluation (0 = idle,
    // 1 = clear, 2..N+1 = MAC steps, N+2 = bias, N+3 = capture, N+4 = done).
    int           t = 0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] exp_q [$];
    logic         prev_valid = 1'b0;

    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] v);
      return ($signed(v) < 0) ? '0 : v;
    endfunction

    function automatic logic [4:0] exp_strobes(input int tt);
      return {tt == 1, (tt >= 2) && (tt <= N + 2), (tt >= 2) && (tt <= N + 1),
              tt != 0, tt == N + 4};
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        t = 0;
        m_result = '0;
      end else if (t == 0) begin
        if (start) t = 1;
      end else if (t == N + 3) begin
        m_result = relu_ref(mac);
        t = N + 4;
      end else if (t == N + 4) begin
        if (ack) t = 0;
      end else begin
        t = t + 1;
      end
    end

    // Monitor: per-cycle strobe/hold checks plus scoreboard pop on valid rise.
    always @(negedge clk) begin
      check("strobes", g, {init, ld_reg, inc, busy, result_valid}, exp_strobes(t));
      check("result_hold", g, result, m_result);
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("valid_without_request", g, result_valid, 0);
        else check("scoreboard_result", g, result, exp_q.pop_front());
      end
      prev_valid = result_valid;
    end

    task automatic step();
      @(negedge clk);
      #1;
    endtask

    // Advance until the reference reaches target; stray acks outside DONE,
    // start dropped after hold cycles.
    task automatic wait_t(input int target, input int hold, input string name);
      int budget = 64;
      int cnt    = 0;
      while (t != target && budget > 0) begin
        ack = (t < N + 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (cnt >= hold) start = 1'b0;
        step();
        cnt++;
        budget--;
      end
      ack = 1'b0;
      if (budget == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout [N=%0d] position=%0d required=%0d", name, N, t, target);
      end
    endtask

    initial begin
      int hold;
      step();
      step();
      check("reset_outputs", g, {init, ld_reg, inc, busy, result_valid, result}, '0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
        repeat ($urandom_range(0, 3)) step();
        case ($urandom_range(0, 2))
          0:       mac = W'($urandom_range(0, 1000));
          1:       mac = -W'($urandom_range(1, 1000));
          default: mac = W'($urandom);
        endcase
        if (i == 0) mac = W'(300);
        if (i == 1) mac = 21'h1FFFF6;
        start = 1'b1;
        exp_q.push_back(relu_ref(mac));
        hold = (i % 4 == 2) ? 1000 : int'($urandom_range(1, 2 * N + 8));
        if (i == 8) begin
          wait_t(3, hold, "reach_acc");
          #2 rst = 1'b1;
          start = 1'b0;
          #1;
          check("rst_async", g, {init, ld_reg, inc, busy, result_valid, result}, '0);
          exp_q.delete();
          step();
          rst = 1'b0;
          continue;
        end
        wait_t(N + 4, hold, "reach_done");
        repeat ($urandom_range(0, 3)) step();
        ack = 1'b1;
        if (i % 4 != 2) start = 1'($urandom_range(0, 1));
        step();
        ack   = 1'b0;
        start = 1'b0;
      end
      step();
      done_cnt++;
    end
  end

  initial begin
    int guard = 0;
    while (done_cnt < NUM && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (done_cnt < NUM) begin
      checks++;
      failures++;
      $display("FAIL global_timeout finished=%0d required=%0d", done_cnt, NUM);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
